// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// beat-counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  // Beat counter width for n beats; at least one bit so N=1 still has a counter.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master = operand producer + result consumer, slave = the adder.
interface bit_serial_adder_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/bit_serial_adder_fa_slice.sv
// Combinational ripple of BITS_PER_CYCLE full-adder cells; also exposes the
// carry into the top cell so the caller can form signed overflow.
module fa_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a_s,
  input  logic [BITS_PER_CYCLE-1:0] b_s,
  input  logic                      c_in,
  output logic [BITS_PER_CYCLE-1:0] s_s,
  output logic                      c_out,
  output logic                      c_msb_in
);

  logic [BITS_PER_CYCLE:0] c;

  always_comb begin
    c    = '0;
    s_s  = '0;
    c[0] = c_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      s_s[i]  = a_s[i] ^ b_s[i] ^ c[i];
      c[i+1]  = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
    c_out    = c[BITS_PER_CYCLE];
    c_msb_in = c[BITS_PER_CYCLE-1];
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle a + b + cin adder, BITS_PER_CYCLE bits per clock, LSB first,
// with valid/ready handshakes on operands and result.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  bit_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);

  generate
    if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("bit_serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  add_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout;
  logic                      slice_cmsb;
  logic [WIDTH-1:0]          acc_shift;

  fa_slice #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_fa_slice (
    .a_s      (a_q[BITS_PER_CYCLE-1:0]),
    .b_s      (b_q[BITS_PER_CYCLE-1:0]),
    .c_in     (carry_q),
    .s_s      (slice_sum),
    .c_out    (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // Slices enter at the MSB end so after N beats the LSB slice sits at bit 0.
  // acc is a working copy; sum only updates on completion so it holds the last result.
  assign acc_shift = (acc_q >> BITS_PER_CYCLE)
                   | (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        acc_d   = acc_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          sum_d   = acc_shift;
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_cmsb;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: five adder configurations on one clock, checked
// against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int NI = 5;
  localparam int WID [NI] = '{8, 8, 4, 4, 4};
  localparam int NB  [NI] = '{8, 2, 4, 2, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid  [NI];
  logic       out_ready [NI];
  logic       cin_v     [NI];
  logic [7:0] a_v       [NI];
  logic [7:0] b_v       [NI];
  logic [7:0] o_sum     [NI];
  logic       o_cout    [NI];
  logic       o_ovf     [NI];
  logic       o_in_rdy  [NI];
  logic       o_out_vld [NI];

  int checks   = 0;
  int failures = 0;

  bit_serial_adder_if #(.WIDTH(8)) if0 ();
  bit_serial_adder_if #(.WIDTH(8)) if1 ();
  bit_serial_adder_if #(.WIDTH(4)) if2 ();
  bit_serial_adder_if #(.WIDTH(4)) if3 ();
  bit_serial_adder_if #(.WIDTH(4)) if4 ();

  bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if0.in_valid = in_valid[0];  assign if0.out_ready = out_ready[0];
  assign if0.a = a_v[0];              assign if0.b = b_v[0];  assign if0.cin = cin_v[0];
  assign o_sum[0] = if0.sum;          assign o_cout[0] = if0.cout;  assign o_ovf[0] = if0.ovf;
  assign o_in_rdy[0] = if0.in_ready;  assign o_out_vld[0] = if0.out_valid;

  assign if1.in_valid = in_valid[1];  assign if1.out_ready = out_ready[1];
  assign if1.a = a_v[1];              assign if1.b = b_v[1];  assign if1.cin = cin_v[1];
  assign o_sum[1] = if1.sum;          assign o_cout[1] = if1.cout;  assign o_ovf[1] = if1.ovf;
  assign o_in_rdy[1] = if1.in_ready;  assign o_out_vld[1] = if1.out_valid;

  assign if2.in_valid = in_valid[2];  assign if2.out_ready = out_ready[2];
  assign if2.a = a_v[2][3:0];         assign if2.b = b_v[2][3:0];  assign if2.cin = cin_v[2];
  assign o_sum[2] = {4'h0, if2.sum};  assign o_cout[2] = if2.cout;  assign o_ovf[2] = if2.ovf;
  assign o_in_rdy[2] = if2.in_ready;  assign o_out_vld[2] = if2.out_valid;

  assign if3.in_valid = in_valid[3];  assign if3.out_ready = out_ready[3];
  assign if3.a = a_v[3][3:0];         assign if3.b = b_v[3][3:0];  assign if3.cin = cin_v[3];
  assign o_sum[3] = {4'h0, if3.sum};  assign o_cout[3] = if3.cout;  assign o_ovf[3] = if3.ovf;
  assign o_in_rdy[3] = if3.in_ready;  assign o_out_vld[3] = if3.out_valid;

  assign if4.in_valid = in_valid[4];  assign if4.out_ready = out_ready[4];
  assign if4.a = a_v[4][3:0];         assign if4.b = b_v[4][3:0];  assign if4.cin = cin_v[4];
  assign o_sum[4] = {4'h0, if4.sum};  assign o_cout[4] = if4.cout;  assign o_ovf[4] = if4.ovf;
  assign o_in_rdy[4] = if4.in_ready;  assign o_out_vld[4] = if4.out_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic model(input int k, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       output logic [7:0] es, output logic ec, output logic eo);
    int w, full, msk;
    w    = WID[k];
    msk  = (1 << w) - 1;
    full = int'(av) + int'(bv) + int'(ci);
    es   = 8'(full & msk);
    ec   = ((full >> w) & 1) != 0;
    eo   = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
  endtask

  task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input bit rnd_ready, input string tag);
    logic [7:0] es;
    logic       ec, eo;
    int         lat, guard;
    model(k, av, bv, ci, es, ec, eo);
    out_ready[k] = 1'b0;
    guard = 0;
    while (!o_in_rdy[k] && guard < 64) begin tick(); guard++; end
    if (guard >= 64) chk({tag, " idle_timeout"}, 32'(o_in_rdy[k]), 32'd1);
    in_valid[k] = 1'b1; a_v[k] = av; b_v[k] = bv; cin_v[k] = ci;
    tick();
    in_valid[k] = 1'b0;
    a_v[k] = 8'($urandom); b_v[k] = 8'($urandom); cin_v[k] = 1'($urandom);
    lat = 0;
    while (!o_out_vld[k] && lat < 64) begin tick(); lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(NB[k]));
    chk({tag, " sum"},  32'(o_sum[k]),  32'(es));
    chk({tag, " cout"}, 32'(o_cout[k]), 32'(ec));
    chk({tag, " ovf"},  32'(o_ovf[k]),  32'(eo));
    guard = 0;
    do begin
      out_ready[k] = rnd_ready ? 1'($urandom) : 1'b1;
      tick();
      guard++;
    end while (!out_ready[k] && guard < 64);
    out_ready[k] = 1'b0;
    chk({tag, " in_ready_after"}, 32'(o_in_rdy[k]), 32'd1);
  endtask

  initial begin
    logic [7:0] hs;
    logic       hc, ho;
    int         seen;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; cin_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    rst = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst in_ready",  32'(o_in_rdy[k]),  32'd1);
      chk("rst out_valid", 32'(o_out_vld[k]), 32'd0);
      chk("rst sum",       32'(o_sum[k]),     32'd0);
      chk("rst cout",      32'(o_cout[k]),    32'd0);
      chk("rst ovf",       32'(o_ovf[k]),     32'd0);
    end
    rst = 1'b0;
    tick();

    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "w8b1 ff+01");
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "w8b1 7f+01");
    do_op(0, 8'h80, 8'h80, 1'b0, 1'b0, "w8b1 80+80");
    do_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, "w8b4 a5+5a+1");

    // Backpressure: result must stay put and new operands must be refused.
    do_op(0, 8'h01, 8'h02, 1'b0, 1'b0, "bp warmup");
    in_valid[0] = 1'b1; a_v[0] = 8'h3C; b_v[0] = 8'h11; cin_v[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    seen = 0;
    while (!o_out_vld[0] && seen < 64) begin tick(); seen++; end
    chk("bp latency", 32'(seen), 32'd8);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'($urandom); a_v[0] = 8'($urandom); b_v[0] = 8'($urandom);
      tick();
      chk("bp out_valid", 32'(o_out_vld[0]), 32'd1);
      chk("bp in_ready",  32'(o_in_rdy[0]),  32'd0);
      chk("bp sum",       32'(o_sum[0]),     32'h4E);
      chk("bp cout",      32'(o_cout[0]),    32'd0);
      chk("bp ovf",       32'(o_ovf[0]),     32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp release in_ready",  32'(o_in_rdy[0]),  32'd1);
    chk("bp release out_valid", 32'(o_out_vld[0]), 32'd0);
    chk("bp hold sum",          32'(o_sum[0]),     32'h4E);

    // Reset abandons an operation mid-RUN.
    in_valid[0] = 1'b1; a_v[0] = 8'h55; b_v[0] = 8'h33; cin_v[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst in_ready",  32'(o_in_rdy[0]),  32'd1);
    chk("midrst out_valid", 32'(o_out_vld[0]), 32'd0);
    chk("midrst sum",       32'(o_sum[0]),     32'd0);
    seen = 0;
    repeat (12) begin tick(); if (o_out_vld[0]) seen++; end
    chk("midrst stale out_valid", 32'(seen), 32'd0);
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, "post rst 10+20");

    for (int n = 0; n < 30; n++) begin
      do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "w8b1 rand");
      do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "w8b4 rand");
    end

    for (int k = 2; k < NI; k++) begin
      for (int v = 0; v < 512; v++) begin
        hs = 8'(v & 15);
        do_op(k, hs, 8'((v >> 4) & 15), 1'((v >> 8) & 1), 1'b1, $sformatf("w4 inst%0d v%0d", k, v));
      end
    end

    model(0, 8'hFF, 8'h01, 1'b1, hs, hc, ho);
    chk("model sanity ff+01+1", {23'd0, hs, hc}, {23'd0, 8'h01, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
